// File: rtl/iic_pkg.sv
// Shared I2C definitions: the target state encoding, the default target address
// and the byte width. iic_master-side code and benches import the same package.
package iic_pkg;

    localparam int         DATA_W           = 8;
    localparam logic [6:0] IIC_DEFAULT_ADDR = 7'h50;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WRITE     = 3'd3,
        WR_ACK    = 3'd4,
        READ      = 3'd5,
        RD_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } iic_state_t;

endpackage

// File: rtl/iic_sync_edge.sv
// Two-flop synchronizer plus a history flop for one raw bus line, with
// single-clk rise/fall strobes derived from the synchronized value.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset; all flops reset to 1 (idle bus)
//   d    - raw pad input, asynchronous to clk
//   q    - synchronized level
//   rise - one-clk strobe on a 0->1 transition of q
//   fall - one-clk strobe on a 1->0 transition of q
module iic_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s_p0, s_p1, s_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_p0 <= 1'b1;
            s_p1 <= 1'b1;
            s_p2 <= 1'b1;
        end else begin
            s_p0 <= d;
            s_p1 <= s_p0;
            s_p2 <= s_p1;
        end
    end

    // s_p1 is the synchronized value, s_p2 its one-clk history.
    assign q    = s_p1;
    assign rise = s_p1 & ~s_p2;
    assign fall = ~s_p1 & s_p2;

endmodule

// File: rtl/iic_slave.sv
// I2C target (slave) for 7-bit addressing. Oversamples SCL/SDA with clk,
// samples data on SCL rise, changes SDA only on SCL fall, never stretches SCL
// and only ever pulls SDA low.
// Ports:
//   clk, rst   - system clock, asynchronous active-high reset
//   scl_in     - raw SCL from the pad
//   sda_in     - raw SDA from the pad
//   sda_oe     - 1 pulls SDA low, 0 releases it
//   rx_data    - last byte written by the master
//   rx_valid   - one-clk pulse when rx_data updates
//   tx_data    - byte returned on a master read
//   tx_req     - one-clk pulse asking for the next tx_data
//   busy       - high from address match until STOP or NACK
//   rw         - direction from the address byte, 1 = master read
module iic_slave
    import iic_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = IIC_DEFAULT_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_req,
    output logic              busy,
    output logic              rw
);

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;

    iic_sync_edge u_scl_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (scl_in),
        .q    (scl_s),
        .rise (scl_rise),
        .fall (scl_fall)
    );

    iic_sync_edge u_sda_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (sda_in),
        .q    (sda_s),
        .rise (sda_rise),
        .fall (sda_fall)
    );

    // ---- bus condition decode (synchronized domain) ----
    // Both lines go through identical synchronizers, so their relative order
    // is preserved and an SDA edge seen while scl_s is high is START/STOP.
    logic start_det, stop_det;
    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;

    iic_state_t        state, state_nxt;
    logic [2:0]        bit_cnt, bit_cnt_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic [DATA_W-1:0] shift_in;
    logic              ack_phase, ack_phase_nxt;
    logic              sda_oe_nxt, rx_valid_nxt, tx_req_nxt, busy_nxt, rw_nxt;
    logic [DATA_W-1:0] rx_data_nxt;

    assign shift_in = {shift[DATA_W-2:0], sda_s};

    // ---- control registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 3'd7;
            ack_phase <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
            rw        <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            ack_phase <= ack_phase_nxt;
            sda_oe    <= sda_oe_nxt;
            rx_data   <= rx_data_nxt;
            rx_valid  <= rx_valid_nxt;
            tx_req    <= tx_req_nxt;
            busy      <= busy_nxt;
            rw        <= rw_nxt;
        end
    end

    // ---- data shift register (no reset; always loaded before use) ----
    always_ff @(posedge clk) begin
        shift <= shift_nxt;
    end

    // ---- next-state / output decode ----
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift;
        ack_phase_nxt = ack_phase;
        sda_oe_nxt    = sda_oe;
        rx_data_nxt   = rx_data;
        rx_valid_nxt  = 1'b0;
        tx_req_nxt    = 1'b0;
        busy_nxt      = busy;
        rw_nxt        = rw;

        if (start_det) begin
            state_nxt     = ADDR;
            bit_cnt_nxt   = 3'd7;
            sda_oe_nxt    = 1'b0;
            busy_nxt      = 1'b0;
            ack_phase_nxt = 1'b0;
        end else if (stop_det) begin
            state_nxt     = IDLE;
            bit_cnt_nxt   = 3'd7;
            sda_oe_nxt    = 1'b0;
            busy_nxt      = 1'b0;
            ack_phase_nxt = 1'b0;
        end else begin
            case (state)
                IDLE, WAIT_STOP: begin
                end

                ADDR: begin
                    if (scl_rise) begin
                        shift_nxt = shift_in;
                        if (bit_cnt == 3'd0) begin
                            bit_cnt_nxt = 3'd7;
                            if (shift_in[7:1] == SLAVE_ADDR) begin
                                rw_nxt        = shift_in[0];
                                busy_nxt      = 1'b1;
                                tx_req_nxt    = shift_in[0];
                                ack_phase_nxt = 1'b0;
                                state_nxt     = ADDR_ACK;
                            end else begin
                                state_nxt = WAIT_STOP;
                            end
                        end else begin
                            bit_cnt_nxt = bit_cnt - 3'd1;
                        end
                    end
                end

                // First SCL fall starts the ACK pulse, the second one ends it.
                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_oe_nxt    = 1'b1;
                            ack_phase_nxt = 1'b1;
                        end else begin
                            ack_phase_nxt = 1'b0;
                            bit_cnt_nxt   = 3'd7;
                            if (state == ADDR_ACK && rw) begin
                                shift_nxt  = tx_data;
                                sda_oe_nxt = ~tx_data[7];
                                state_nxt  = READ;
                            end else begin
                                sda_oe_nxt = 1'b0;
                                state_nxt  = WRITE;
                            end
                        end
                    end
                end

                WRITE: begin
                    if (scl_rise) begin
                        shift_nxt = shift_in;
                        if (bit_cnt == 3'd0) begin
                            rx_data_nxt   = shift_in;
                            rx_valid_nxt  = 1'b1;
                            bit_cnt_nxt   = 3'd7;
                            ack_phase_nxt = 1'b0;
                            state_nxt     = WR_ACK;
                        end else begin
                            bit_cnt_nxt = bit_cnt - 3'd1;
                        end
                    end
                end

                // shift[7] is the bit currently on the bus.
                READ: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            sda_oe_nxt  = 1'b0;
                            bit_cnt_nxt = 3'd7;
                            state_nxt   = RD_ACK;
                        end else begin
                            shift_nxt   = {shift[DATA_W-2:0], 1'b0};
                            sda_oe_nxt  = ~shift[6];
                            bit_cnt_nxt = bit_cnt - 3'd1;
                        end
                    end
                end

                // Entered on a fall, so the next fall always follows an ACK rise.
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            tx_req_nxt = 1'b1;
                        end else begin
                            busy_nxt  = 1'b0;
                            state_nxt = WAIT_STOP;
                        end
                    end else if (scl_fall) begin
                        shift_nxt   = tx_data;
                        sda_oe_nxt  = ~tx_data[7];
                        bit_cnt_nxt = 3'd7;
                        state_nxt   = READ;
                    end
                end

                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule
